// File: rtl/spi_reg_arbiter_pkg.sv
// spi_reg_arbiter_pkg
//   Shared types for the SPI/local register-bank arbiter: FSM state
//   encoding, requester (owner) encoding and the winner-selection helper.
package spi_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_SPI = 1'b0,
    OWNER_LOC = 1'b1
  } owner_t;

  // Winner when the FSM is idle. With rr=0 SPI always wins contention;
  // with rr=1 the requester that did not win last time gets the bank.
  function automatic owner_t arb_pick(input logic   spi_pend,
                                      input logic   loc_req,
                                      input logic   rr,
                                      input owner_t last_owner);
    arb_pick = OWNER_LOC;
    if (spi_pend && !(loc_req && rr && (last_owner == OWNER_SPI)))
      arb_pick = OWNER_SPI;
  endfunction

endpackage

// File: rtl/spi_reg_arbiter_if.sv
// spi_reg_arbiter_if
//   Local host port of the register-bank arbiter.
//   loc_req/loc_we/loc_addr/loc_wdata : request, held until loc_gnt
//   loc_gnt    : 1-cycle pulse in the cycle the access issues
//   loc_rvalid : 1-cycle pulse, loc_rdata valid
//   Modports: master = host side, slave = arbiter side.
interface spi_reg_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              loc_req;
  logic              loc_we;
  logic [ADDR_W-1:0] loc_addr;
  logic [DATA_W-1:0] loc_wdata;
  logic              loc_gnt;
  logic              loc_rvalid;
  logic [DATA_W-1:0] loc_rdata;

  modport master (output loc_req, loc_we, loc_addr, loc_wdata,
                  input  loc_gnt, loc_rvalid, loc_rdata);
  modport slave  (input  loc_req, loc_we, loc_addr, loc_wdata,
                  output loc_gnt, loc_rvalid, loc_rdata);
endinterface

// File: rtl/spi_reg_arbiter_strobe_sync.sv
// spi_strobe_sync
//   Brings an asynchronous strobe into the clk domain through SYNC_STAGES
//   flops and emits a one-cycle pulse on its rising edge.
//   clk, reset : system clock, synchronous active-high reset
//   i_async    : asynchronous strobe
//   o_pulse    : single-cycle rising-edge pulse (clk domain)
module spi_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_pulse
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;
endmodule

// File: rtl/spi_reg_arbiter.sv
// spi_reg_arbiter
//   Shares an 8-bit register bank between the SPI slave core (async
//   read/write strobes) and a local host port. SPI strobes are synchronised
//   and edge-detected, requests are arbitrated, and bank accesses are
//   sequenced IDLE -> ISSUE -> (WAIT x RD_LAT) -> IDLE.
//   clk, reset          : system clock, synchronous active-high reset
//   spi_read/spi_write  : async SPI strobes; spi_addr/spi_wdata stable while high
//   spi_rdata           : last SPI read data, held until the next SPI read
//   spi_overrun         : sticky, strobe edge arrived while SPI request pending
//   loc                 : local host port (spi_reg_arbiter_if.slave)
//   reg_en/we/addr/wdata: bank access; reg_rdata valid RD_LAT cycles after reg_en
//   busy                : FSM not idle
//   Build option: define SPI_REG_ARB_RR_EN for round-robin arbitration;
//   otherwise SPI has fixed priority over the local port.
module spi_reg_arbiter
  import spi_reg_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_read,
  input  logic              spi_write,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic [DATA_W-1:0] spi_rdata,
  output logic              spi_overrun,
  spi_reg_arbiter_if.slave  loc,
  output logic              reg_en,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic w_rd_edge, w_wr_edge;

  spi_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
    .clk(clk), .reset(reset), .i_async(spi_read),  .o_pulse(w_rd_edge));
  spi_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
    .clk(clk), .reset(reset), .i_async(spi_write), .o_pulse(w_wr_edge));

  state_t            r_state, w_state_nxt;
  owner_t            r_owner, w_sel_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_spi_pend, r_spi_we, r_spi_overrun;
  logic [ADDR_W-1:0] r_spi_addr;
  logic [DATA_W-1:0] r_spi_wdata;
  logic [DATA_W-1:0] r_spi_rdata, r_loc_rdata;
  logic              r_loc_rvalid;
  logic              w_any_req, w_clr_spi, w_rd_last;

  assign w_any_req = r_spi_pend | loc.loc_req;
  assign w_clr_spi = (r_state == ST_ISSUE) && (r_owner == OWNER_SPI);
  assign w_rd_last = (r_cnt == CNT_W'(RD_LAT - 1));

`ifdef SPI_REG_ARB_RR_EN
  // Starts as local so the first contention goes to SPI.
  owner_t r_last_owner;

  always_ff @(posedge clk) begin
    if (reset)
      r_last_owner <= OWNER_LOC;
    else if ((r_state == ST_IDLE) && w_any_req)
      r_last_owner <= w_sel_owner;
  end

  assign w_sel_owner = arb_pick(r_spi_pend, loc.loc_req, 1'b1, r_last_owner);
`else
  assign w_sel_owner = arb_pick(r_spi_pend, loc.loc_req, 1'b0, OWNER_LOC);
`endif

  // SPI request capture: the first edge is kept, any edge while a request is
  // still pending (or read+write together) flags overrun. Write wins a tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_spi_pend    <= 1'b0;
      r_spi_we      <= 1'b0;
      r_spi_addr    <= '0;
      r_spi_wdata   <= '0;
      r_spi_overrun <= 1'b0;
    end else begin
      if (w_rd_edge || w_wr_edge) begin
        if (r_spi_pend || (w_rd_edge && w_wr_edge))
          r_spi_overrun <= 1'b1;
        if (!r_spi_pend) begin
          r_spi_pend  <= 1'b1;
          r_spi_we    <= w_wr_edge;
          r_spi_addr  <= spi_addr;
          r_spi_wdata <= spi_wdata;
        end
      end
      if (w_clr_spi)
        r_spi_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_req) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = r_we ? ST_IDLE : ST_WAIT;
      ST_WAIT:  if (w_rd_last) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Access registers and read-data capture; reset here aborts any access
  // in flight without capturing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner      <= OWNER_SPI;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_spi_rdata  <= '0;
      r_loc_rdata  <= '0;
      r_loc_rvalid <= 1'b0;
    end else begin
      r_loc_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_any_req) begin
          r_owner <= w_sel_owner;
          if (w_sel_owner == OWNER_SPI) begin
            r_we    <= r_spi_we;
            r_addr  <= r_spi_addr;
            r_wdata <= r_spi_wdata;
          end else begin
            r_we    <= loc.loc_we;
            r_addr  <= loc.loc_addr;
            r_wdata <= loc.loc_wdata;
          end
        end
        ST_ISSUE: r_cnt <= '0;
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_rd_last) begin
            if (r_owner == OWNER_SPI) begin
              r_spi_rdata <= reg_rdata;
            end else begin
              r_loc_rdata  <= reg_rdata;
              r_loc_rvalid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign reg_en         = (r_state == ST_ISSUE);
  assign reg_we         = reg_en & r_we;
  assign reg_addr       = r_addr;
  assign reg_wdata      = r_wdata;
  assign loc.loc_gnt    = reg_en && (r_owner == OWNER_LOC);
  assign loc.loc_rvalid = r_loc_rvalid;
  assign loc.loc_rdata  = r_loc_rdata;
  assign spi_rdata      = r_spi_rdata;
  assign spi_overrun    = r_spi_overrun;
  assign busy           = (r_state != ST_IDLE);
endmodule
